// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and store-lane helpers for dmem_bridge
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RDONE = 2'd3
  } state_t;

  // Word accesses enable every lane; byte accesses enable only the addressed lane.
  function automatic logic [3:0] byte_en(input logic [1:0] addr, input logic isbyte);
    logic [3:0] be;
    if (isbyte) begin
      be = 4'b0001 << addr;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] store_fmt(input logic [31:0] data, input logic isbyte);
    return isbyte ? {4{data[7:0]}} : data;
  endfunction

endpackage

// File: rtl/stbuf_entry.sv
// rtl/stbuf_entry.sv - single-entry posted-store buffer (valid/addr/be/data)
module stbuf_entry #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          capture,
  input  logic          clear,
  input  logic [AW-1:0] addr_in,
  input  logic [3:0]    be_in,
  input  logic [31:0]   data_in,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [3:0]    be,
  output logic [31:0]   data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   data_q, data_d;

  // A capture in the same cycle as a clear wins: the entry stays valid with the new store.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      valid_d = 1'b1;
      addr_d  = addr_in;
      be_d    = be_in;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      data_q  <= 32'd0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign be    = be_q;
  assign data  = data_q;

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage data-memory bridge: posted store, blocking load, req/ack bus
module dmem_bridge
  import mem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic          storeselectM,
  input  logic [AW-1:0] aluoutM,
  input  logic [31:0]   writedataM,
  output logic [31:0]   readdataM,
  output logic          stallM,
  output logic          alignerr,
  output logic [31:0]   stallcnt,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata
);

  state_t        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          alignerr_q, alignerr_d;
  logic [31:0]   stallcnt_q, stallcnt_d;

  logic          sb_valid, sb_capture, sb_clear;
  logic [AW-1:0] sb_addr;
  logic [3:0]    sb_be;
  logic [31:0]   sb_data;

  logic          is_load, is_store, drain_ack, stall, misaligned;
  logic [AW-1:0] acc_addr;
  logic [3:0]    acc_be;
  logic [31:0]   acc_data;

  // A load and store together is illegal; treating it as a load keeps the buffer untouched.
  assign is_load    = memreadM;
  assign is_store   = memwriteM & ~memreadM;
  assign acc_addr   = {aluoutM[AW-1:2], 2'b00};
  assign acc_be     = byte_en(aluoutM[1:0], storeselectM);
  assign acc_data   = store_fmt(writedataM, storeselectM);
  assign misaligned = (memreadM | memwriteM) & ~storeselectM & (aluoutM[1:0] != 2'b00);
  assign drain_ack  = (state_q == ST_WRITE) & bus_req_q & bus_ack;

  always_comb begin
    stall = 1'b0;
    if (state_q == ST_READ) begin
      stall = 1'b1;
    end else if (is_load) begin
      stall = (state_q != ST_RDONE);
    end else if (is_store) begin
      stall = sb_valid & ~drain_ack;
    end
  end

  assign sb_capture = is_store & ~stall;
  assign sb_clear   = drain_ack;

  stbuf_entry #(
    .AW(AW)
  ) u_stbuf (
    .clk     (clk),
    .reset   (reset),
    .capture (sb_capture),
    .clear   (sb_clear),
    .addr_in (acc_addr),
    .be_in   (acc_be),
    .data_in (acc_data),
    .valid   (sb_valid),
    .addr    (sb_addr),
    .be      (sb_be),
    .data    (sb_data)
  );

  // Transactions launch only from IDLE, which guarantees a low bus_req cycle between them.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (sb_valid) begin
          state_d     = ST_WRITE;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = sb_addr;
          bus_be_d    = sb_be;
          bus_wdata_d = sb_data;
        end else if (is_load) begin
          state_d    = ST_READ;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = acc_addr;
          bus_be_d   = acc_be;
        end else if (sb_capture) begin
          state_d     = ST_WRITE;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = acc_addr;
          bus_be_d    = acc_be;
          bus_wdata_d = acc_data;
        end
      end
      ST_WRITE: begin
        if (bus_ack) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end
      end
      ST_READ: begin
        if (bus_ack) begin
          state_d   = ST_RDONE;
          bus_req_d = 1'b0;
          rdata_d   = bus_rdata;
        end
      end
      ST_RDONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    alignerr_d = alignerr_q | misaligned;
    stallcnt_d = stallcnt_q;
    if (stall && (stallcnt_q != 32'hFFFF_FFFF)) begin
      stallcnt_d = stallcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      alignerr_q  <= 1'b0;
      stallcnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      alignerr_q  <= alignerr_d;
      stallcnt_q  <= stallcnt_d;
    end
  end

  assign readdataM = rdata_q;
  assign stallM    = stall;
  assign alignerr  = alignerr_q;
  assign stallcnt  = stallcnt_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
